imem_loader: RTL

- Parametrised program-load-and-run controller sitting between a byte stream source (bench or debug link) and the processor's byte-wide instruction memory write port plus its pc_enable.
- Replaces manual loading: write bytes, drop We, raise pc_enable, stop at a target PC.
- Adds length checking, valid/ready flow control, stop-PC halt, run-cycle watchdog and abort.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types for the instruction-memory program loader.
//   state_t : controller states (IDLE, LOAD, SETTLE, RUN, HALT)
//   err_t   : sticky error code reported on the error port
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    HALT
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE = 2'd0;
  localparam err_t ERR_LEN  = 2'd1;
  localparam err_t ERR_WDOG = 2'd2;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: program-load-and-run controller.
// Accepts a byte stream (in_data/in_valid/in_ready), writes it to the
// instruction memory write port (mem_we/mem_addr/mem_wdata), then runs the
// processor (pc_enable) until pc_output hits stop_pc or the run-cycle
// watchdog expires.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : launch a load (samples length/stop_pc/max_cycles),
//                         force return to IDLE
//   length              : bytes to load, legal 1..DEPTH
//   stop_pc, pc_output  : halt target and processor's current PC
//   max_cycles          : run-cycle limit, 0 disables the watchdog
//   in_data/valid/ready : byte stream handshake
//   mem_we/addr/wdata   : registered memory write port (one-cycle latency)
//   pc_enable           : processor run enable
//   busy, done, error   : status (done and error are sticky)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned WDOG_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] length,
  input  logic [PC_W-1:0]   stop_pc,
  input  logic [WDOG_W-1:0] max_cycles,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [PC_W-1:0]   pc_output,
  output logic              pc_enable,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error
);

  state_t              state_q,      state_d;
  logic                in_ready_q,   in_ready_d;
  logic                mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [BYTE_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic                pc_enable_q,  pc_enable_d;
  logic                done_q,       done_d;
  err_t                error_q,      error_d;
  logic [ADDR_W-1:0]   cnt_q,        cnt_d;
  logic [ADDR_W-1:0]   len_q,        len_d;
  logic [PC_W-1:0]     stop_pc_q,    stop_pc_d;
  logic [WDOG_W-1:0]   max_cycles_q, max_cycles_d;
  logic [WDOG_W-1:0]   wdog_q,       wdog_d;

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pc_enable_d  = pc_enable_q;
    done_d       = done_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    stop_pc_d    = stop_pc_q;
    max_cycles_d = max_cycles_q;
    wdog_d       = wdog_q;

    if (abort) begin
      // done/error deliberately retained across abort
      state_d     = IDLE;
      in_ready_d  = 1'b0;
      pc_enable_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            done_d       = 1'b0;
            len_d        = length;
            stop_pc_d    = stop_pc;
            max_cycles_d = max_cycles;
            if (length == '0 || length > ADDR_W'(DEPTH)) begin
              error_d = ERR_LEN;
              state_d = IDLE;
            end else begin
              error_d    = ERR_NONE;
              cnt_d      = '0;
              in_ready_d = 1'b1;
              state_d    = LOAD;
            end
          end
        end

        LOAD: begin
          if (in_valid && in_ready_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q;
            mem_wdata_d = in_data;
            cnt_d       = cnt_q + ADDR_W'(1);
            if (cnt_q == len_q - ADDR_W'(1)) begin
              in_ready_d = 1'b0;
              state_d    = SETTLE;
            end
          end
        end

        // The last write is on the port while in SETTLE; leaving SETTLE
        // registers mem_we=0 with pc_enable still 0, so the first RUN cycle
        // is the guaranteed quiet cycle before the processor starts.
        SETTLE: begin
          state_d = RUN;
          wdog_d  = '0;
        end

        RUN: begin
          if (pc_output == stop_pc_q) begin
            // stop-PC match takes priority over a simultaneous watchdog expiry
            pc_enable_d = 1'b0;
            done_d      = 1'b1;
            state_d     = HALT;
          end else if (pc_enable_q && max_cycles_q != '0 &&
                       (wdog_q + WDOG_W'(1)) == max_cycles_q) begin
            pc_enable_d = 1'b0;
            error_d     = ERR_WDOG;
            state_d     = HALT;
          end else begin
            pc_enable_d = 1'b1;
            // count only cycles in which the processor was actually enabled
            if (pc_enable_q) begin
              wdog_d = wdog_q + WDOG_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pc_enable_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= ERR_NONE;
      cnt_q        <= '0;
      len_q        <= '0;
      stop_pc_q    <= '0;
      max_cycles_q <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pc_enable_q  <= pc_enable_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      stop_pc_q    <= stop_pc_d;
      max_cycles_q <= max_cycles_d;
      wdog_q       <= wdog_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_enable = pc_enable_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = (state_q == LOAD) || (state_q == SETTLE) || (state_q == RUN);

endmodule
